imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory from a byte stream. Accepts a framed image (magic, base address, length, payload) over a valid/ready byte interface, drives a byte-wide write port into the instruction memory, and holds the core in reset until the image is fully and correctly loaded. Sits between the host byte link (UART receiver or testbench) and the write side of the instruction memory.

## Interface
- `MEM_SIZE`, 512: instruction memory size in bytes; legal byte addresses are 0..MEM_SIZE-1.
- `MAGIC`, 8'hA5: frame start byte.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_valid_i`  in  1  source has a byte on `byte_data_i`.
- `byte_data_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader can accept a byte this cycle.
- `wr_en_o`  out  1  one-cycle byte write strobe to instruction memory.
- `wr_addr_o`  out  32  byte address of the write.
- `wr_data_o`  out  8  byte to write.
- `busy_o`  out  1  frame in progress (state is neither IDLE, DONE nor ERR).
- `done_o`  out  1  image loaded successfully, sticky.
- `err_o`  out  1  frame rejected, sticky.
- `cpu_rst_n_o`  out  1  core reset, active-low; low until DONE.

## Operation
- Byte transfer occurs on a rising edge where `byte_valid_i && byte_ready_o`. `byte_ready_o` = 1 in every state except DONE and ERR.
- Frame format, little-endian: MAGIC, ADDR[7:0], ADDR[15:8], LEN[7:0], LEN[15:8], LEN payload bytes, then CSUM if checksum is enabled.
- FSM states: IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE: a byte equal to MAGIC moves to ADDR0. Any other byte is consumed and discarded; the FSM stays in IDLE.
- ADDR0 -> ADDR1 -> LEN0 -> LEN1: each state captures one byte into a 16-bit base or length register.
- At the LEN1 transfer, a range check is done in 17-bit arithmetic: base + len > MEM_SIZE -> ERR. Otherwise len == 0 -> DONE, or CSUM when checksum is enabled. Otherwise -> DATA, with an index counter cleared to 0.
- DATA: each accepted byte produces one write: `wr_addr_o` = base + index (zero-extended to 32 bits), `wr_data_o` = byte. The index then increments. After the transfer with index == len-1, go to DONE, or to CSUM when checksum is enabled.
- DONE: `done_o` = 1 and `cpu_rst_n_o` = 1. Terminal until `rst_n`.
- ERR: `err_o` = 1 and `cpu_rst_n_o` stays 0. Terminal until `rst_n`.
- Writes already issued are never undone on error or reset.

## Timing
- Reset values: `byte_ready_o`=1 (state IDLE), `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `cpu_rst_n_o`=0.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `byte_valid_i` to `byte_ready_o`.
- Write latency: `wr_en_o` is high for exactly the one cycle after a payload byte is accepted, with address and data stable in that cycle. `wr_en_o` returns to 0 the next cycle unless another byte was accepted.
- Throughput: one byte per cycle, back-to-back transfers allowed in all states.
- Gaps are allowed: `byte_valid_i` low in any state holds the state and all counters.
- DONE and ERR are entered on the edge of the final transfer. `done_o`, `err_o` and `cpu_rst_n_o` change one edge later, so the final `wr_en_o` pulse coincides with or precedes the `done_o` rise.
- Asynchronous `rst_n` assertion in any state returns the FSM to IDLE, clears all counters and outputs at once, and drives `cpu_rst_n_o` low.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - CSUM state is present.
  - A running 8-bit sum of payload bytes, mod 256, is kept.
  - The trailing byte must make sum + CSUM == 8'h00: match -> DONE, mismatch -> ERR.
  - With len == 0, CSUM must be 8'h00.
- Not defined:
  - No CSUM state and no sum register.
  - The last payload byte, or LEN1 with len == 0, goes directly to DONE.

## Test plan
- Load without checksum:
  - Stimulus: A5 10 00 04 00 13 00 00 00.
  - Response: four `wr_en_o` pulses at addresses 0x10..0x13 with data 13, 00, 00, 00.
  - `done_o`=1 and `cpu_rst_n_o`=1 one cycle after the last write. `byte_ready_o`=0 afterwards.
- Junk before magic:
  - Stimulus: 00 FF A5 00 00 01 00 6F.
  - Response: no writes for 00 or FF; a single write of 6F at address 0; then DONE.
- Range error:
  - Stimulus: A5 FE 01 04 00 with MEM_SIZE=512.
  - Response: 0x1FE + 4 = 514 > 512, so `err_o`=1, no `wr_en_o` pulse, `cpu_rst_n_o` stays 0.
- Checksum, with `IMEM_LOADER_CSUM_EN` defined:
  - Stimulus: A5 00 00 02 00 01 02 FD.
  - Response: DONE.
  - Same frame ending in FC: ERR, but both writes still occurred.
- Stalls and reset:
  - Stimulus: send a frame with `byte_valid_i` toggled every other cycle, then assert `rst_n` low after the 2nd payload byte.
  - Response: writes match the accepted bytes only. On reset all outputs return to reset values in the same cycle.
  - A new frame then loads correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte stream in, byte-wide instruction-memory write port out.
// Pure wiring; timing is set by the loader behind the slave modport.
// byte_valid_i/byte_ready_o handshake; the write port has no backpressure.
interface imem_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        wr_en_o;
  logic [31:0] wr_addr_o;
  logic [7:0]  wr_data_o;

  // Host side: supplies bytes and observes the memory writes.
  modport master (
    output byte_valid_i, byte_data_i,
    input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  // Loader side.
  modport slave (
    input  byte_valid_i, byte_data_i,
    output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/ADDR/LEN/payload[/CSUM] frames into imem byte writes, holds core in reset until done.
// Latency: write strobe one cycle after each accepted payload byte; done/err/cpu_rst_n one edge after final transfer.
// Backpressure: byte_ready_o is state-decoded, low only in DONE/ERR. Optional trailing checksum via IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int unsigned MEM_SIZE = 512,
  parameter logic [7:0]  MAGIC    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_loader_if.slave lif,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         cpu_rst_n_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  // State reached after the last payload byte (or after LEN1 when len is zero).
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e S_FINAL = S_CSUM;
`else
  localparam state_e S_FINAL = S_DONE;
`endif

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  csum_total;
`endif

  logic        byte_ready;
  logic        xfer;
  logic [15:0] len_new;
  logic [16:0] range_end;

  assign byte_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign xfer       = lif.byte_valid_i && byte_ready;
  // Full length as it will be once the high byte lands; range check uses 17 bits so it cannot wrap.
  assign len_new    = {lif.byte_data_i, len_q[7:0]};
  assign range_end  = {1'b0, base_q} + {1'b0, len_new};
`ifdef IMEM_LOADER_CSUM_EN
  assign csum_total = sum_q + lif.byte_data_i;
`endif

  // Next-state, field capture and write-port generation for one accepted byte.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // Status flags trail the terminal state by one edge and are sticky.
    done_d    = done_q | (state_q == S_DONE);
    err_d     = err_q  | (state_q == S_ERR);
`ifdef IMEM_LOADER_CSUM_EN
    sum_d     = sum_q;
`endif
    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          if (lif.byte_data_i == MAGIC) state_d = S_ADDR0;
        end
        S_ADDR0: begin
          base_d[7:0] = lif.byte_data_i;
          state_d     = S_ADDR1;
        end
        S_ADDR1: begin
          base_d[15:8] = lif.byte_data_i;
          state_d      = S_LEN0;
        end
        S_LEN0: begin
          len_d[7:0] = lif.byte_data_i;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d = len_new;
          idx_d = '0;
`ifdef IMEM_LOADER_CSUM_EN
          sum_d = '0;
`endif
          if (range_end > MEM_LIMIT) state_d = S_ERR;
          else if (len_new == 16'd0) state_d = S_FINAL;
          else                       state_d = S_DATA;
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = 32'(base_q) + 32'(idx_q);
          wr_data_d = lif.byte_data_i;
          idx_d     = idx_q + 16'd1;
`ifdef IMEM_LOADER_CSUM_EN
          sum_d     = csum_total;
`endif
          if (idx_q == len_q - 16'd1) state_d = S_FINAL;
        end
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM: begin
          state_d = (csum_total == 8'h00) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign lif.byte_ready_o = byte_ready;
  assign lif.wr_en_o      = wr_en_q;
  assign lif.wr_addr_o    = wr_addr_q;
  assign lif.wr_data_o    = wr_data_q;
  assign busy_o           = (state_q != S_IDLE) && byte_ready;
  assign done_o           = done_q;
  assign err_o            = err_q;
  // The core leaves reset exactly when the image is known good.
  assign cpu_rst_n_o      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus randomized frames against a frame-level model.
// Model predicts outputs per cycle from the accepted byte history; compare runs on every falling edge.
// Inputs driven on falling edges; acceptance follows the DUT's byte_ready_o.
module tb_imem_loader;

  localparam int unsigned MEM_SIZE = 512;
  localparam logic [7:0]  MAGIC    = 8'hA5;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, err, cpu_rst_n;
  int   total = 0;
  int   bad = 0;

  imem_loader_if lif ();

  imem_loader #(.MEM_SIZE(MEM_SIZE), .MAGIC(MAGIC)) dut (
    .clk(clk), .rst_n(rst_n), .lif(lif),
    .busy_o(busy), .done_o(done), .err_o(err), .cpu_rst_n_o(cpu_rst_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  logic [7:0]  m_q[$];      // bytes of the current frame, from MAGIC on
  int          m_term;      // 0 running, 1 done, 2 error
  logic        exp_wr_en;
  logic [31:0] exp_wr_addr;
  logic [7:0]  exp_wr_data;
  logic        exp_done, exp_err;
  logic [39:0] wr_log[$];   // observed writes {addr, data}

  task automatic model_byte(input logic [7:0] b);
    int n, base, len, s;
    if (m_q.size() == 0) begin
      if (b == MAGIC) m_q.push_back(b);
    end else begin
      m_q.push_back(b);
      n = m_q.size();
      base = {m_q[2], m_q[1]};
      len  = (n >= 5) ? int'({m_q[4], m_q[3]}) : 0;
      if (n < 5) begin
        // header still arriving
      end else if (n == 5) begin
        if (base + len > int'(MEM_SIZE)) m_term = 2;
        else if (len == 0 && !CSUM)      m_term = 1;
      end else if (n <= 5 + len) begin
        exp_wr_en   = 1'b1;
        exp_wr_addr = 32'(base + n - 6);
        exp_wr_data = b;
        if (n == 5 + len && !CSUM) m_term = 1;
      end else begin
        s = 0;
        for (int i = 5; i < n; i++) s += m_q[i];
        m_term = (s % 256 == 0) ? 1 : 2;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_term = 0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
      exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      exp_done  = (m_term == 1);
      exp_err   = (m_term == 2);
      exp_wr_en = 1'b0;
      if (lif.byte_valid_i && m_term == 0) model_byte(lif.byte_data_i);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", lif.byte_ready_o, m_term == 0);
      check("busy", busy, m_q.size() > 0 && m_term == 0);
      check("done", done, exp_done);
      check("err", err, exp_err);
      check("cpu_rst_n", cpu_rst_n, exp_done);
      check("wr_en", lif.wr_en_o, exp_wr_en);
      if (exp_wr_en) begin
        check("wr_addr", lif.wr_addr_o, exp_wr_addr);
        check("wr_data", lif.wr_data_o, exp_wr_data);
      end
      if (lif.wr_en_o) wr_log.push_back({lif.wr_addr_o, lif.wr_data_o});
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [39:0] log_at(input int i);
    return (wr_log.size() > i) ? wr_log[i] : '1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    lif.byte_valid_i = 1'b1;
    lif.byte_data_i  = b;
    w = 0;
    while (lif.byte_ready_o !== 1'b1 && w < 16) begin
      @(negedge clk);
      w++;
    end
    if (w >= 16) begin
      total++; bad++;
      $display("FAIL send_timeout: byte=%0h ready stuck at %0b", b, lif.byte_ready_o);
    end else begin
      @(negedge clk);
    end
    lif.byte_valid_i = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps
  task automatic send_frame(input bq_t fr, input int mode);
    int gap;
    foreach (fr[i]) begin
      if (m_term != 0) break;
      gap = (mode == 1) ? 1 : (mode == 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_byte(fr[i], gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    lif.byte_valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr;
    int base, len, s;
    lif.byte_valid_i = 1'b0;
    lif.byte_data_i  = 8'h00;

    // Reset values, literal.
    #2;
    check("rst_ready", lif.byte_ready_o, 1);
    check("rst_wr_en", lif.wr_en_o, 0);
    check("rst_wr_addr", lif.wr_addr_o, 0);
    check("rst_wr_data", lif.wr_data_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    do_reset();

    // Plain load: four writes at 0x10..0x13.
    fr = '{8'hA5, 8'h10, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    if (CSUM) fr.push_back(8'hED);
    send_frame(fr, 0);
`ifndef IMEM_LOADER_CSUM_EN
    check("f1_last_wr_en", lif.wr_en_o, 1);
    check("f1_done_lags", done, 0);
`endif
    settle();
    check("f1_nwr", wr_log.size(), 4);
    check("f1_w0", log_at(0), {32'h10, 8'h13});
    check("f1_w1", log_at(1), {32'h11, 8'h00});
    check("f1_w2", log_at(2), {32'h12, 8'h00});
    check("f1_w3", log_at(3), {32'h13, 8'h00});
    check("f1_done", done, 1);
    check("f1_cpu_rst_n", cpu_rst_n, 1);
    check("f1_ready", lif.byte_ready_o, 0);
    do_reset();

    // Junk ahead of MAGIC.
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h6F};
    if (CSUM) fr.push_back(8'h91);
    send_frame(fr, 0);
    settle();
    check("junk_nwr", wr_log.size(), 1);
    check("junk_w0", log_at(0), {32'h0, 8'h6F});
    check("junk_done", done, 1);
    do_reset();

    // Range error: 0x1FE + 4 = 514.
    fr = '{8'hA5, 8'hFE, 8'h01, 8'h04, 8'h00, 8'h11, 8'h22};
    send_frame(fr, 0);
    settle();
    check("range_err", err, 1);
    check("range_nwr", wr_log.size(), 0);
    check("range_cpu_rst_n", cpu_rst_n, 0);
    do_reset();

    // Range boundary: 0x1FC + 4 = 512 is legal.
    fr = '{8'hA5, 8'hFC, 8'h01, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CSUM) fr.push_back(8'hF6);
    send_frame(fr, 2);
    settle();
    check("bound_done", done, 1);
    check("bound_last", log_at(3), {32'h1FF, 8'h04});
    do_reset();

    // Checksum frame (without the checksum byte when the feature is off).
    fr = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02};
    if (CSUM) fr.push_back(8'hFD);
    send_frame(fr, 0);
    settle();
    check("cs_good_done", done, 1);
    check("cs_good_nwr", wr_log.size(), 2);
    do_reset();
`ifdef IMEM_LOADER_CSUM_EN
    fr = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'hFC};
    send_frame(fr, 0);
    settle();
    check("cs_bad_err", err, 1);
    check("cs_bad_nwr", wr_log.size(), 2);
    check("cs_bad_cpu_rst_n", cpu_rst_n, 0);
    do_reset();
`endif

    // Stalled frame, reset after the 2nd payload byte.
    fr = '{8'hA5, 8'h20, 8'h00, 8'h05, 8'h00, 8'h11, 8'h22};
    send_frame(fr, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", lif.wr_en_o, 0);
    check("mid_rst_addr", lif.wr_addr_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", lif.byte_ready_o, 1);
    check("mid_rst_cpu_rst_n", cpu_rst_n, 0);
    check("mid_nwr", wr_log.size(), 2);
    check("mid_w1", log_at(1), {32'h21, 8'h22});
    do_reset();
    fr = '{8'hA5, 8'h30, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB};
    if (CSUM) fr.push_back(8'h9B);
    send_frame(fr, 1);
    settle();
    check("reload_done", done, 1);
    check("reload_w0", log_at(0), {32'h30, 8'hAA});
    check("reload_w1", log_at(1), {32'h31, 8'hBB});
    do_reset();

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      fr.delete();
      repeat ($urandom_range(0, 2)) fr.push_back(8'($urandom_range(0, 8'hA4)));
      len  = (f % 5 == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 10));
      case ($urandom_range(0, 5))
        0:       base = int'(MEM_SIZE) - len;
        1:       base = int'(MEM_SIZE) - len + 1;
        default: base = int'($urandom_range(0, 530));
      endcase
      if (base < 0) base = 0;
      fr.push_back(MAGIC);
      fr.push_back(8'(base)); fr.push_back(8'(base >> 8));
      fr.push_back(8'(len));  fr.push_back(8'(len >> 8));
      s = 0;
      for (int i = 0; i < len; i++) begin
        fr.push_back(8'($urandom));
        s += fr[fr.size() - 1];
      end
      if (CSUM) fr.push_back(8'(256 - (s % 256)) + (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00));
      send_frame(fr, 2);
      settle();
      check("rand_end", done | err, 1);
      do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
